// File: rtl/mmcm_drp_reconfig_ctrl.sv
// rtl/mmcm_drp_reconfig_ctrl.sv - DRP read-modify-write reconfiguration sequencer for one MMCM
module mmcm_drp_reconfig_ctrl #(
    parameter int RST_HOLD     = 8,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic        i_sys_clk,
    input  logic        i_glb_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [6:0]  i_req_addr,
    input  logic [15:0] i_req_data,
    input  logic [15:0] i_req_mask,
    input  logic        i_req_last,
    output logic        o_drp_den,
    output logic        o_drp_dwe,
    output logic [6:0]  o_drp_daddr,
    output logic [15:0] o_drp_di,
    input  logic [15:0] i_drp_do,
    input  logic        i_drp_drdy,
    output logic        o_mmcm_rst,
    input  logic        i_mmcm_locked,
    output logic        o_busy,
    output logic        o_core_rst_req,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_err_code
);

    localparam int MAX_A       = (RST_HOLD > DRDY_TIMEOUT) ? RST_HOLD : DRDY_TIMEOUT;
    localparam int MAX_CNT     = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int CNT_W       = $clog2(MAX_CNT + 1);
    // LOCKED may still be high from before the release; skip this many cycles.
    localparam int LOCK_IGNORE = 4;

    typedef enum logic [3:0] {
        IDLE, HOLD_RST, WAIT_ITEM, RD, RD_WAIT, WR, WR_WAIT,
        RELEASE, WAIT_LOCK, DONE, ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]         addr_q, addr_d;
    logic [15:0]        data_q, data_d;
    logic [15:0]        mask_q, mask_d;
    logic               last_q, last_d;
    logic [15:0]        di_q, di_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               req_ready_q, req_ready_d;
    logic               den_q, den_d;
    logic               dwe_q, dwe_d;
    logic               mmcm_rst_q, mmcm_rst_d;
    logic               busy_q, busy_d;
    logic               core_rst_q, core_rst_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               lock_meta_q, lock_sync_q;
    logic               accept;

    assign accept = i_req_valid & req_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        mask_d     = mask_q;
        last_d     = last_q;
        di_d       = di_q;
        err_code_d = err_code_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d     = i_req_addr;
                    data_d     = i_req_data;
                    mask_d     = i_req_mask;
                    last_d     = i_req_last;
                    err_code_d = 2'b00;
                    cnt_d      = '0;
                    state_d    = HOLD_RST;
                end
            end
            HOLD_RST: begin
                if (cnt_q == CNT_W'(RST_HOLD - 1)) state_d = RD;
                else                               cnt_d   = cnt_q + CNT_W'(1);
            end
            WAIT_ITEM: begin
                if (accept) begin
                    addr_d  = i_req_addr;
                    data_d  = i_req_data;
                    mask_d  = i_req_mask;
                    last_d  = i_req_last;
                    state_d = RD;
                end
            end
            // cnt counts cycles since den: den cycle leaves it at 1.
            RD: begin
                cnt_d   = CNT_W'(1);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (i_drp_drdy) begin
                    di_d    = (i_drp_do & mask_q) | (data_q & ~mask_q);
                    state_d = WR;
                end else if (cnt_q == CNT_W'(DRDY_TIMEOUT - 1)) begin
                    err_code_d = 2'b01;
                    state_d    = ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR: begin
                cnt_d   = CNT_W'(1);
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (i_drp_drdy) begin
                    state_d = last_q ? RELEASE : WAIT_ITEM;
                end else if (cnt_q == CNT_W'(DRDY_TIMEOUT - 1)) begin
                    err_code_d = 2'b01;
                    state_d    = ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                cnt_d   = CNT_W'(1);
                state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_sync_q && (cnt_q > CNT_W'(LOCK_IGNORE))) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    err_code_d = 2'b10;
                    state_d    = ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with state_q.
        req_ready_d = (state_d == IDLE) || (state_d == WAIT_ITEM);
        den_d       = (state_d == RD) || (state_d == WR);
        dwe_d       = (state_d == WR);
        mmcm_rst_d  = state_d inside {HOLD_RST, WAIT_ITEM, RD, RD_WAIT, WR, WR_WAIT};
        busy_d      = state_d inside {HOLD_RST, WAIT_ITEM, RD, RD_WAIT, WR, WR_WAIT,
                                      RELEASE, WAIT_LOCK};
        core_rst_d  = busy_d;
        done_d      = (state_d == DONE);
        err_d       = (state_d == ERROR);
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_glb_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            last_q      <= 1'b0;
            di_q        <= '0;
            err_code_q  <= 2'b00;
            req_ready_q <= 1'b0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            mmcm_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            core_rst_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            last_q      <= last_d;
            di_q        <= di_d;
            err_code_q  <= err_code_d;
            req_ready_q <= req_ready_d;
            den_q       <= den_d;
            dwe_q       <= dwe_d;
            mmcm_rst_q  <= mmcm_rst_d;
            busy_q      <= busy_d;
            core_rst_q  <= core_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
            lock_meta_q <= i_mmcm_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    assign o_req_ready    = req_ready_q;
    assign o_drp_den      = den_q;
    assign o_drp_dwe      = dwe_q;
    assign o_drp_daddr    = addr_q;
    assign o_drp_di       = di_q;
    assign o_mmcm_rst     = mmcm_rst_q;
    assign o_busy         = busy_q;
    assign o_core_rst_req = core_rst_q;
    assign o_done         = done_q;
    assign o_err          = err_q;
    assign o_err_code     = err_code_q;

endmodule

// File: tb/tb_mmcm_drp_reconfig_ctrl.sv
// tb/tb_mmcm_drp_reconfig_ctrl.sv - self-checking bench for mmcm_drp_reconfig_ctrl
`timescale 1ns/1ps
module tb_mmcm_drp_reconfig_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        glb_reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [6:0]  req_addr = '0;
    logic [15:0] req_data = '0;
    logic [15:0] req_mask = '0;
    logic        req_last = 1'b0;
    logic [15:0] drp_do = '0;
    logic        drp_drdy = 1'b0;
    logic        locked = 1'b0;

    logic        o_req_ready, o_drp_den, o_drp_dwe, o_mmcm_rst, o_busy;
    logic        o_core_rst_req, o_done, o_err;
    logic [6:0]  o_drp_daddr;
    logic [15:0] o_drp_di;
    logic [1:0]  o_err_code;

    mmcm_drp_reconfig_ctrl dut (
        .i_sys_clk      (clk),
        .i_glb_reset    (glb_reset),
        .i_req_valid    (req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_addr     (req_addr),
        .i_req_data     (req_data),
        .i_req_mask     (req_mask),
        .i_req_last     (req_last),
        .o_drp_den      (o_drp_den),
        .o_drp_dwe      (o_drp_dwe),
        .o_drp_daddr    (o_drp_daddr),
        .o_drp_di       (o_drp_di),
        .i_drp_do       (drp_do),
        .i_drp_drdy     (drp_drdy),
        .o_mmcm_rst     (o_mmcm_rst),
        .i_mmcm_locked  (locked),
        .o_busy         (o_busy),
        .o_core_rst_req (o_core_rst_req),
        .o_done         (o_done),
        .o_err          (o_err),
        .o_err_code     (o_err_code)
    );

    typedef struct {
        logic [6:0]  addr;
        logic [15:0] data;
        logic [15:0] mask;
        logic [15:0] rd_val;
        logic [15:0] exp_wr;
        int          gap;
    } vec_t;
    vec_t vecs [4];

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [128];
    int   cyc = 0;
    bit   pend = 0, pend_drop = 0, spur = 0, awaiting = 0, hold = 0, prev_rst = 0;
    logic [15:0] pend_val = '0;
    int   read_cnt = 0, drop_read_n = 0, ready_viol = 0;
    int   done_cnt = 0, err_cnt = 0, done_cyc = -1, err_cyc = -1;
    int   rst_rise_cyc = -1, rst_fall_cyc = -1;
    bit   err_rst = 0, err_busy = 0;
    logic [6:0]  log_addr [$];
    bit          log_we   [$];
    logic [15:0] log_di   [$];
    int          log_cyc  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] la(input int k);
        return (k < log_addr.size()) ? 32'(log_addr[k]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] lw(input int k);
        return (k < log_we.size()) ? 32'(log_we[k]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] ld(input int k);
        return (k < log_di.size()) ? 32'(log_di[k]) : 32'hFFFF_FFFF;
    endfunction
    function automatic int lc(input int k);
        return (k < log_cyc.size()) ? log_cyc[k] : -100000;
    endfunction

    // One clock: sample DUT at the falling edge, then act as the DRP slave.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (drp_drdy) awaiting = 0;
        if (o_drp_den) awaiting = 1;
        if (o_mmcm_rst && !prev_rst) begin rst_rise_cyc = cyc; hold = 1; end
        if (!o_mmcm_rst && prev_rst) rst_fall_cyc = cyc;
        if (o_drp_den) hold = 0;
        if (o_err || o_done || glb_reset) begin awaiting = 0; hold = 0; end
        if (o_req_ready && (awaiting || hold || (o_busy && !o_mmcm_rst) || o_done || o_err))
            ready_viol++;
        prev_rst = o_mmcm_rst;
        if (o_done) begin done_cnt++; done_cyc = cyc; end
        if (o_err) begin err_cnt++; err_cyc = cyc; err_rst = o_mmcm_rst; err_busy = o_busy; end
        drp_drdy = 1'b0;
        if (pend) begin
            pend = 0;
            if (!pend_drop) begin drp_drdy = 1'b1; drp_do = pend_val; end
        end
        if (spur) begin spur = 0; drp_drdy = 1'b1; drp_do = 16'hDEAD; end
        if (o_drp_den) begin
            log_addr.push_back(o_drp_daddr);
            log_we.push_back(o_drp_dwe);
            log_di.push_back(o_drp_di);
            log_cyc.push_back(cyc);
            pend = 1; pend_drop = 0;
            if (!o_drp_dwe) begin
                read_cnt++;
                pend_val  = mem[o_drp_daddr];
                pend_drop = (read_cnt == drop_read_n);
            end else begin
                mem[o_drp_daddr] = o_drp_di;
            end
        end
    endtask

    task automatic clear_log();
        log_addr.delete(); log_we.delete(); log_di.delete(); log_cyc.delete();
        done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
        rst_rise_cyc = -1; rst_fall_cyc = -1; read_cnt = 0; drop_read_n = 0; pend = 0;
    endtask

    task automatic load_vec(input int idx, input bit last);
        req_addr = vecs[idx].addr;
        req_data = vecs[idx].data;
        req_mask = vecs[idx].mask;
        req_last = last;
        mem[vecs[idx].addr] = vecs[idx].rd_val;
    endtask

    task automatic send_item(input int idx, input bit last);
        int n = 0;
        bit ok = 0;
        load_vec(idx, last);
        req_valid = 1'b1;
        while (n < 300) begin
            if (o_req_ready) begin ok = 1; tick(); break; end
            tick(); n++;
        end
        req_valid = 1'b0;
        check("item_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_end(input int bound);
        int n = 0;
        while ((done_cnt + err_cnt) == 0 && n < bound) begin tick(); n++; end
        check("sequence_terminated", 32'((done_cnt + err_cnt) != 0), 32'd1);
    endtask

    function automatic logic any_out();
        return |{o_req_ready, o_drp_den, o_drp_dwe, o_drp_daddr, o_drp_di, o_mmcm_rst,
                 o_busy, o_core_rst_req, o_done, o_err, o_err_code};
    endfunction

    initial begin
        vecs[0] = '{7'h08, 16'h1041, 16'hF000, 16'hA3C3, 16'hA041, 0};
        vecs[1] = '{7'h09, 16'hFFFF, 16'h00FF, 16'h1234, 16'hFF34, 0};
        vecs[2] = '{7'h14, 16'h0000, 16'hFFFF, 16'hBEEF, 16'hBEEF, 5};
        vecs[3] = '{7'h4E, 16'h5A5A, 16'h0000, 16'h0F0F, 16'h5A5A, 20};
        for (int i = 0; i < 128; i++) mem[i] = '0;

        // Reset state
        repeat (3) tick();
        check("reset_outputs_zero", 32'(any_out()), 32'd0);
        glb_reset = 1'b0;
        tick();
        check("ready_after_reset", 32'(o_req_ready), 32'd1);
        check("busy_after_reset", 32'(o_busy), 32'd0);

        // Single item, lock 100 cycles after release
        clear_log();
        send_item(0, 1'b1);
        for (int n = 0; n < 200 && rst_fall_cyc < 0; n++) tick();
        repeat (100) tick();
        locked = 1'b1;
        wait_end(300);
        check("t1_done_cnt", 32'(done_cnt), 32'd1);
        check("t1_err_cnt", 32'(err_cnt), 32'd0);
        check("t1_ops", 32'(log_addr.size()), 32'd2);
        check("t1_rd_addr", la(0), 32'h08);
        check("t1_rd_we", lw(0), 32'd0);
        check("t1_wr_addr", la(1), 32'h08);
        check("t1_wr_we", lw(1), 32'd1);
        check("t1_wr_data", ld(1), 32'hA041);
        check("t1_rst_hold", 32'(lc(0) - rst_rise_cyc), 32'd8);
        check("t1_release_after_wr", 32'(rst_fall_cyc - lc(1)), 32'd2);
        check("t1_lock_latency", 32'(done_cyc - rst_fall_cyc), 32'd103);
        check("t1_err_code", 32'(o_err_code), 32'd0);
        check("t1_busy_done", 32'(o_busy), 32'd0);
        check("t1_core_rst_done", 32'(o_core_rst_req), 32'd0);
        repeat (3) tick();
        check("t1_done_pulse", 32'(done_cnt), 32'd1);
        locked = 1'b0;
        repeat (3) tick();

        // Lock never arrives
        clear_log();
        send_item(3, 1'b1);
        wait_end(70000);
        check("t4_err_cnt", 32'(err_cnt), 32'd1);
        check("t4_lock_timeout", 32'(err_cyc - rst_fall_cyc), 32'd65536);
        check("t4_err_code", 32'(o_err_code), 32'd2);
        check("t4_rst_at_err", 32'(err_rst), 32'd0);
        repeat (2) tick();

        // Three-item stream, LOCKED stuck high through the release
        clear_log();
        locked = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            repeat (vecs[j].gap) tick();
            send_item(j, j == 3);
            if (j == 1) check("t2_err_code_cleared", 32'(o_err_code), 32'd0);
        end
        wait_end(500);
        check("t2_done_cnt", 32'(done_cnt), 32'd1);
        check("t2_ops", 32'(log_addr.size()), 32'd6);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("t2_rd_addr%0d", j), la(2 * j), 32'(vecs[j + 1].addr));
            check($sformatf("t2_rd_we%0d", j), lw(2 * j), 32'd0);
            check($sformatf("t2_wr_addr%0d", j), la(2 * j + 1), 32'(vecs[j + 1].addr));
            check($sformatf("t2_wr_data%0d", j), ld(2 * j + 1), 32'(vecs[j + 1].exp_wr));
        end
        check("t2_stale_lock_ignored", 32'(done_cyc - rst_fall_cyc), 32'd6);
        locked = 1'b0;
        repeat (3) tick();

        // No drdy on the second read
        clear_log();
        drop_read_n = 2;
        send_item(1, 1'b0);
        send_item(2, 1'b1);
        wait_end(500);
        check("t3_err_cnt", 32'(err_cnt), 32'd1);
        check("t3_done_cnt", 32'(done_cnt), 32'd0);
        check("t3_ops", 32'(log_addr.size()), 32'd3);
        check("t3_drdy_timeout", 32'(err_cyc - lc(2)), 32'd64);
        check("t3_err_code", 32'(o_err_code), 32'd1);
        check("t3_rst_at_err", 32'(err_rst), 32'd0);
        check("t3_busy_at_err", 32'(err_busy), 32'd0);
        repeat (5) tick();
        check("t3_err_code_held", 32'(o_err_code), 32'd1);
        check("t3_err_pulse", 32'(err_cnt), 32'd1);

        // Reset while waiting for read data
        clear_log();
        locked = 1'b1;
        send_item(0, 1'b1);
        for (int n = 0; n < 100 && log_addr.size() == 0; n++) tick();
        tick();
        glb_reset = 1'b1;
        tick();
        check("t5_outputs_zero", 32'(any_out()), 32'd0);
        glb_reset = 1'b0;
        tick();
        check("t5_ready_back", 32'(o_req_ready), 32'd1);
        check("t5_no_write", 32'(log_addr.size()), 32'd1);
        clear_log();
        send_item(0, 1'b1);
        wait_end(500);
        check("t5_done_cnt", 32'(done_cnt), 32'd1);
        check("t5_wr_data", ld(1), 32'hA041);

        // Spurious drdy in IDLE/HOLD_RST and valid held while busy
        repeat (3) tick();
        clear_log();
        spur = 1;
        repeat (3) tick();
        check("t6_idle_busy", 32'(o_busy), 32'd0);
        check("t6_idle_ops", 32'(log_addr.size()), 32'd0);
        load_vec(0, 1'b1);
        req_valid = 1'b1;
        for (int n = 0; n < 50 && rst_rise_cyc < 0; n++) tick();
        tick();
        tick();
        spur = 1;
        wait_end(500);
        req_valid = 1'b0;
        check("t6_ops", 32'(log_addr.size()), 32'd2);
        check("t6_rst_hold", 32'(lc(0) - rst_rise_cyc), 32'd8);
        check("t6_wr_data", ld(1), 32'hA041);
        repeat (5) tick();
        check("t6_no_extra_accept", 32'(o_busy), 32'd0);
        check("t6_done_cnt", 32'(done_cnt), 32'd1);
        check("ready_only_idle_wait", 32'(ready_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
